// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage and IF/ID pipeline register.
//
// Issues at most one instruction-memory request at a time and copes with
// variable response latency. It also handles decode stalls, through a
// one-entry skid buffer, and redirects that arrive while a request is still
// in flight. A redirect during a pending request drains that request so its
// stale data is never used.
//
// Ports
//   clk, reset          core clock, synchronous active-high reset
//   StallD, FlushD      hold / bubble the IF/ID register
//   PCSrcE, PCTargetE   branch/jump redirect from execute
//   imem_req/addr       instruction memory request
//   imem_rdata/valid    instruction memory response
//   InstrD, PCD,
//   PCPlus4D, ValidD    IF/ID register contents
//   op, funct3,
//   funct7b5            decode fields sliced from InstrD for the controller
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5
);

    typedef enum logic [1:0] {StFetch, StDrain, StHeld} state_e;

    state_e      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        waiting_q, waiting_d;   // request issued, response not yet seen
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;

    logic        resp;
    logic        load_new;
    logic [31:0] new_instr;
    logic [31:0] new_pc;

    // Reset gates the request so a late response to an abandoned fetch is ignored.
    assign imem_req  = (state_q != StHeld) && !reset;
    assign imem_addr = (state_q == StFetch && !waiting_q) ? pcf_q : req_addr_q;
    assign resp      = imem_req && imem_valid;

    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        req_addr_d  = req_addr_q;
        waiting_d   = waiting_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        load_new    = 1'b0;
        new_instr   = imem_rdata;
        new_pc      = imem_addr;

        unique case (state_q)
            StFetch: begin
                if (resp) begin
                    waiting_d = 1'b0;
                    if (PCSrcE) begin
                        pcf_d = PCTargetE;
                    end else if (!StallD) begin
                        load_new = 1'b1;
                        pcf_d    = imem_addr + 32'd4;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = imem_addr;
                        pcf_d       = imem_addr + 32'd4;
                        state_d     = StHeld;
                    end
                end else begin
                    // Capture the address so it stays stable until the response.
                    waiting_d  = 1'b1;
                    req_addr_d = imem_addr;
                    if (PCSrcE) begin
                        pcf_d   = PCTargetE;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (PCSrcE) begin
                    pcf_d = PCTargetE;
                end
                if (resp) begin
                    waiting_d = 1'b0;
                    state_d   = StFetch;
                end
            end
            StHeld: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = StFetch;
                end else if (!StallD) begin
                    load_new  = 1'b1;
                    new_instr = buf_instr_q;
                    new_pc    = buf_pc_q;
                    state_d   = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StFetch;
            pcf_q      <= RESET_PC;
            req_addr_q <= RESET_PC;
            waiting_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcf_q      <= pcf_d;
            req_addr_q <= req_addr_d;
            waiting_q  <= waiting_d;
        end
    end

    // Skid buffer contents are only read after being written in StFetch.
    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc_q    <= buf_pc_d;
    end

    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
        end else if (load_new) begin
            InstrD   <= new_instr;
            PCD      <= new_pc;
            PCPlus4D <= new_pc + 32'd4;
            ValidD   <= 1'b1;
        end else begin
            ValidD   <= 1'b0;
        end
    end

    assign op       = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];

endmodule
